// File: rtl/wd_router_if.sv
// Signal bundle between the AW stage, write master M1, the three write slaves and the W router.
// The router connects through the slave modport. The environment driving it connects through the master modport.
interface wd_router_if #(
  parameter int DATA_BITS = 32,
  parameter int STRB_BITS = 4,
  parameter int LEN_BITS  = 4
);
  // AW handshakes observed on each slave port, and the length held by the AW mux
  logic                 AWVALID_S0;
  logic                 AWREADY_S0;
  logic                 AWVALID_S1;
  logic                 AWREADY_S1;
  logic                 AWVALID_SDEFAULT;
  logic                 AWREADY_SDEFAULT;
  logic [LEN_BITS-1:0]  AWLEN_M;

  // Master M1 write-data channel
  logic [DATA_BITS-1:0] WDATA_M1;
  logic [STRB_BITS-1:0] WSTRB_M1;
  logic                 WLAST_M1;
  logic                 WVALID_M1;
  logic                 WREADY_M1;

  // Slave-side write-data channels
  logic [DATA_BITS-1:0] WDATA_S0;
  logic [DATA_BITS-1:0] WDATA_S1;
  logic [DATA_BITS-1:0] WDATA_SDEFAULT;
  logic [STRB_BITS-1:0] WSTRB_S0;
  logic [STRB_BITS-1:0] WSTRB_S1;
  logic [STRB_BITS-1:0] WSTRB_SDEFAULT;
  logic                 WLAST_S0;
  logic                 WLAST_S1;
  logic                 WLAST_SDEFAULT;
  logic                 WVALID_S0;
  logic                 WVALID_S1;
  logic                 WVALID_SDEFAULT;
  logic                 WREADY_S0;
  logic                 WREADY_S1;
  logic                 WREADY_SDEFAULT;

  // Status toward the AW and B stages
  logic                 aw_hold;
  logic                 w_done;
  logic                 wlast_err;

  modport slave (
    input  AWVALID_S0, AWREADY_S0, AWVALID_S1, AWREADY_S1,
           AWVALID_SDEFAULT, AWREADY_SDEFAULT, AWLEN_M,
           WDATA_M1, WSTRB_M1, WLAST_M1, WVALID_M1,
           WREADY_S0, WREADY_S1, WREADY_SDEFAULT,
    output WREADY_M1,
           WDATA_S0, WDATA_S1, WDATA_SDEFAULT,
           WSTRB_S0, WSTRB_S1, WSTRB_SDEFAULT,
           WLAST_S0, WLAST_S1, WLAST_SDEFAULT,
           WVALID_S0, WVALID_S1, WVALID_SDEFAULT,
           aw_hold, w_done, wlast_err
  );

  modport master (
    output AWVALID_S0, AWREADY_S0, AWVALID_S1, AWREADY_S1,
           AWVALID_SDEFAULT, AWREADY_SDEFAULT, AWLEN_M,
           WDATA_M1, WSTRB_M1, WLAST_M1, WVALID_M1,
           WREADY_S0, WREADY_S1, WREADY_SDEFAULT,
    input  WREADY_M1,
           WDATA_S0, WDATA_S1, WDATA_SDEFAULT,
           WSTRB_S0, WSTRB_S1, WSTRB_SDEFAULT,
           WLAST_S0, WLAST_S1, WLAST_SDEFAULT,
           WVALID_S0, WVALID_S1, WVALID_SDEFAULT,
           aw_hold, w_done, wlast_err
  );
endinterface

// File: rtl/wd_router.sv
// AXI write-data router for master M1. It latches the slave that won the AW handshake and that burst's length.
// It steers W beats to that slave until the beat counter runs out. Only one write is outstanding at a time.
module wd_router #(
  parameter int DATA_BITS = 32,
  parameter int STRB_BITS = 4,
  parameter int LEN_BITS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  wd_router_if.slave  bus
);

  typedef enum logic {
    ST_IDLE,
    ST_DATA
  } state_e;

  typedef enum logic [1:0] {
    TGT_S0,
    TGT_S1,
    TGT_SDEF
  } target_e;

  state_e              state_q;
  target_e             target_q;
  logic [LEN_BITS-1:0] remaining_q;
  logic                wlast_err_q;
  logic                w_done_q;

  logic                aw_0;
  logic                aw_1;
  logic                aw_d;
  logic                in_data;
  logic                last_beat;
  logic                tgt_ready;
  logic                beat_hs;
  logic [DATA_BITS-1:0] wdata;
  logic [STRB_BITS-1:0] wstrb;

  assign aw_0      = bus.AWVALID_S0 & bus.AWREADY_S0;
  assign aw_1      = bus.AWVALID_S1 & bus.AWREADY_S1;
  assign aw_d      = bus.AWVALID_SDEFAULT & bus.AWREADY_SDEFAULT;
  assign in_data   = (state_q == ST_DATA);
  assign last_beat = (remaining_q == '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    tgt_ready = 1'b0;
    case (target_q)
      TGT_S0:   tgt_ready = bus.WREADY_S0;
      TGT_S1:   tgt_ready = bus.WREADY_S1;
      TGT_SDEF: tgt_ready = bus.WREADY_SDEFAULT;
      default:  tgt_ready = 1'b0;
    endcase
  end

  assign beat_hs = in_data & bus.WVALID_M1 & tgt_ready;

  // Data and strobes go to every slave unconditionally; only WVALID selects the target.
  assign wdata              = bus.WDATA_M1;
  assign wstrb              = bus.WSTRB_M1;
  assign bus.WDATA_S0       = wdata;
  assign bus.WDATA_S1       = wdata;
  assign bus.WDATA_SDEFAULT = wdata;
  assign bus.WSTRB_S0       = wstrb;
  assign bus.WSTRB_S1       = wstrb;
  assign bus.WSTRB_SDEFAULT = wstrb;

  assign bus.WLAST_S0       = last_beat;
  assign bus.WLAST_S1       = last_beat;
  assign bus.WLAST_SDEFAULT = last_beat;

  assign bus.WVALID_S0       = in_data & (target_q == TGT_S0)   & bus.WVALID_M1;
  assign bus.WVALID_S1       = in_data & (target_q == TGT_S1)   & bus.WVALID_M1;
  assign bus.WVALID_SDEFAULT = in_data & (target_q == TGT_SDEF) & bus.WVALID_M1;
  assign bus.WREADY_M1       = in_data & tgt_ready;

  assign bus.aw_hold   = in_data;
  assign bus.w_done    = w_done_q;
  assign bus.wlast_err = wlast_err_q;

  // NOTE: state registers take non-blocking assignments, so every read in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      target_q    <= TGT_S0;
      remaining_q <= '0;
      wlast_err_q <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      w_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (aw_0 | aw_1 | aw_d) begin
            if (aw_0)      target_q <= TGT_S0;
            else if (aw_1) target_q <= TGT_S1;
            else           target_q <= TGT_SDEF;
            remaining_q <= bus.AWLEN_M;
            state_q     <= ST_DATA;
          end
        end
        ST_DATA: begin
          // The burst length comes from the counter. A WLAST that disagrees with it is only flagged.
          if (beat_hs) begin
            if (bus.WLAST_M1 != last_beat) wlast_err_q <= 1'b1;
            if (last_beat) begin
              w_done_q <= 1'b1;
              state_q  <= ST_IDLE;
            end else begin
              remaining_q <= remaining_q - LEN_BITS'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wd_router.sv
// Directed bench for wd_router. Each scenario task drives its own stimulus and compares against hand-derived values.
module tb_wd_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  wd_router_if bus ();

  wd_router dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge. Outputs are sampled 1 unit after that, well away from any edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.AWVALID_S0 = 0; bus.AWREADY_S0 = 0;
    bus.AWVALID_S1 = 0; bus.AWREADY_S1 = 0;
    bus.AWVALID_SDEFAULT = 0; bus.AWREADY_SDEFAULT = 0;
    bus.AWLEN_M = '0;
    bus.WDATA_M1 = '0; bus.WSTRB_M1 = '0; bus.WLAST_M1 = 0; bus.WVALID_M1 = 0;
    bus.WREADY_S0 = 0; bus.WREADY_S1 = 0; bus.WREADY_SDEFAULT = 0;
  endtask

  task automatic drive_aw(input int k, input logic [3:0] len);
    bus.AWVALID_S0       = (k == 0); bus.AWREADY_S0       = (k == 0);
    bus.AWVALID_S1       = (k == 1); bus.AWREADY_S1       = (k == 1);
    bus.AWVALID_SDEFAULT = (k == 2); bus.AWREADY_SDEFAULT = (k == 2);
    bus.AWLEN_M = len;
  endtask

  task automatic clear_aw();
    drive_aw(-1, 4'h0);
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.WREADY_S0 = 1; bus.WVALID_M1 = 1;
    rst = 1;
    step(); step();
    n_cmp++; if (bus.aw_hold !== 1'b0)   begin n_bad++; $display("FAIL reset_aw_hold got %b want 0", bus.aw_hold); end
    n_cmp++; if (bus.w_done !== 1'b0)    begin n_bad++; $display("FAIL reset_w_done got %b want 0", bus.w_done); end
    n_cmp++; if (bus.wlast_err !== 1'b0) begin n_bad++; $display("FAIL reset_wlast_err got %b want 0", bus.wlast_err); end
    n_cmp++; if (bus.WREADY_M1 !== 1'b0) begin n_bad++; $display("FAIL reset_wready_m1 got %b want 0", bus.WREADY_M1); end
    n_cmp++; if ({bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT} !== 3'b000)
      begin n_bad++; $display("FAIL reset_wvalid got %b want 000", {bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT}); end
    rst = 0;
    idle_inputs();
    step();
  endtask

  task automatic test_single_beat();
    drive_aw(0, 4'h0);
    #1;
    n_cmp++; if (bus.aw_hold !== 1'b0) begin n_bad++; $display("FAIL single_hold_before got %b want 0", bus.aw_hold); end
    step();
    clear_aw();
    bus.WDATA_M1 = 32'hDEADBEEF; bus.WSTRB_M1 = 4'hF; bus.WLAST_M1 = 1; bus.WVALID_M1 = 1; bus.WREADY_S0 = 1;
    #1;
    n_cmp++; if (bus.aw_hold !== 1'b1) begin n_bad++; $display("FAIL single_hold got %b want 1", bus.aw_hold); end
    n_cmp++; if ({bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT} !== 3'b100)
      begin n_bad++; $display("FAIL single_wvalid got %b want 100", {bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT}); end
    n_cmp++; if (bus.WLAST_S0 !== 1'b1) begin n_bad++; $display("FAIL single_wlast got %b want 1", bus.WLAST_S0); end
    n_cmp++; if (bus.WREADY_M1 !== 1'b1) begin n_bad++; $display("FAIL single_wready got %b want 1", bus.WREADY_M1); end
    n_cmp++; if (bus.WDATA_S1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_wdata_bcast got %h want deadbeef", bus.WDATA_S1); end
    n_cmp++; if (bus.WSTRB_SDEFAULT !== 4'hF) begin n_bad++; $display("FAIL single_wstrb_bcast got %h want f", bus.WSTRB_SDEFAULT); end
    n_cmp++; if (bus.w_done !== 1'b0) begin n_bad++; $display("FAIL single_done_early got %b want 0", bus.w_done); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (bus.w_done !== 1'b1)  begin n_bad++; $display("FAIL single_done got %b want 1", bus.w_done); end
    n_cmp++; if (bus.aw_hold !== 1'b0) begin n_bad++; $display("FAIL single_hold_drop got %b want 0", bus.aw_hold); end
    step();
    n_cmp++; if (bus.w_done !== 1'b0)  begin n_bad++; $display("FAIL single_done_pulse got %b want 0", bus.w_done); end
  endtask

  // WREADY_S1 pattern 1,0,1,1,0,1; beats handshake on cycles 0,2,3,5 with remaining 3,2,1,0.
  task automatic test_burst_s1();
    logic [5:0] rdy_pat  = 6'b101101; // bit i is cycle i
    logic [5:0] last_pat = 6'b110000;
    drive_aw(1, 4'h3);
    step();
    clear_aw();
    for (int i = 0; i < 6; i++) begin
      bus.WVALID_M1 = 1; bus.WDATA_M1 = 32'h1000 + i; bus.WSTRB_M1 = 4'h3;
      bus.WREADY_S1 = rdy_pat[i]; bus.WLAST_M1 = last_pat[i];
      #1;
      n_cmp++; if (bus.WLAST_S1 !== last_pat[i]) begin n_bad++; $display("FAIL burst_wlast[%0d] got %b want %b", i, bus.WLAST_S1, last_pat[i]); end
      n_cmp++; if (bus.WREADY_M1 !== rdy_pat[i]) begin n_bad++; $display("FAIL burst_wready[%0d] got %b want %b", i, bus.WREADY_M1, rdy_pat[i]); end
      n_cmp++; if ({bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT} !== 3'b010)
        begin n_bad++; $display("FAIL burst_wvalid[%0d] got %b want 010", i, {bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT}); end
      n_cmp++; if (bus.w_done !== 1'b0) begin n_bad++; $display("FAIL burst_done_early[%0d] got %b want 0", i, bus.w_done); end
      step();
    end
    idle_inputs();
    #1;
    n_cmp++; if (bus.w_done !== 1'b1)    begin n_bad++; $display("FAIL burst_done got %b want 1", bus.w_done); end
    n_cmp++; if (bus.wlast_err !== 1'b0) begin n_bad++; $display("FAIL burst_err got %b want 0", bus.wlast_err); end
    step();
    n_cmp++; if (bus.w_done !== 1'b0)    begin n_bad++; $display("FAIL burst_done_once got %b want 0", bus.w_done); end
  endtask

  task automatic test_same_cycle();
    drive_aw(0, 4'h1);
    bus.WVALID_M1 = 1; bus.WREADY_S0 = 1; bus.WDATA_M1 = 32'hA5A5_0000;
    #1;
    n_cmp++; if (bus.WREADY_M1 !== 1'b0) begin n_bad++; $display("FAIL same_wready_aw got %b want 0", bus.WREADY_M1); end
    n_cmp++; if (bus.WVALID_S0 !== 1'b0) begin n_bad++; $display("FAIL same_wvalid_aw got %b want 0", bus.WVALID_S0); end
    step();
    clear_aw();
    #1;
    n_cmp++; if (bus.WREADY_M1 !== 1'b1) begin n_bad++; $display("FAIL same_wready_next got %b want 1", bus.WREADY_M1); end
    n_cmp++; if (bus.WLAST_S0 !== 1'b0)  begin n_bad++; $display("FAIL same_wlast_beat0 got %b want 0", bus.WLAST_S0); end
    step();
    bus.WLAST_M1 = 1;
    #1;
    n_cmp++; if (bus.WLAST_S0 !== 1'b1)  begin n_bad++; $display("FAIL same_wlast_beat1 got %b want 1", bus.WLAST_S0); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (bus.w_done !== 1'b1)    begin n_bad++; $display("FAIL same_done got %b want 1", bus.w_done); end
    step();
  endtask

  task automatic test_wlast_err();
    drive_aw(1, 4'h1);
    step();
    clear_aw();
    bus.WVALID_M1 = 1; bus.WREADY_S1 = 1; bus.WLAST_M1 = 1;
    #1;
    n_cmp++; if (bus.WLAST_S1 !== 1'b0) begin n_bad++; $display("FAIL err_wlast_beat0 got %b want 0", bus.WLAST_S1); end
    step();
    n_cmp++; if (bus.wlast_err !== 1'b1) begin n_bad++; $display("FAIL err_flag got %b want 1", bus.wlast_err); end
    n_cmp++; if (bus.aw_hold !== 1'b1)   begin n_bad++; $display("FAIL err_still_busy got %b want 1", bus.aw_hold); end
    n_cmp++; if (bus.w_done !== 1'b0)    begin n_bad++; $display("FAIL err_no_early_done got %b want 0", bus.w_done); end
    n_cmp++; if (bus.WLAST_S1 !== 1'b1)  begin n_bad++; $display("FAIL err_wlast_beat1 got %b want 1", bus.WLAST_S1); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (bus.w_done !== 1'b1)    begin n_bad++; $display("FAIL err_done got %b want 1", bus.w_done); end
    step();
    n_cmp++; if (bus.wlast_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", bus.wlast_err); end
  endtask

  task automatic test_default_slave();
    bus.WREADY_S0 = 1; bus.WREADY_S1 = 1; bus.WREADY_SDEFAULT = 0;
    drive_aw(2, 4'h2);
    step();
    clear_aw();
    bus.WVALID_M1 = 1; bus.WDATA_M1 = 32'h0BAD_F00D; bus.WSTRB_M1 = 4'h5;
    #1;
    n_cmp++; if (bus.WREADY_M1 !== 1'b0) begin n_bad++; $display("FAIL def_stall_wready got %b want 0", bus.WREADY_M1); end
    n_cmp++; if ({bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT} !== 3'b001)
      begin n_bad++; $display("FAIL def_wvalid got %b want 001", {bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT}); end
    step();
    n_cmp++; if (bus.WDATA_SDEFAULT !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL def_stall_data got %h want 0badf00d", bus.WDATA_SDEFAULT); end
    n_cmp++; if (bus.WLAST_SDEFAULT !== 1'b0) begin n_bad++; $display("FAIL def_stall_wlast got %b want 0", bus.WLAST_SDEFAULT); end
    bus.WREADY_SDEFAULT = 1;
    for (int i = 0; i < 3; i++) begin
      bus.WLAST_M1 = (i == 2);
      #1;
      n_cmp++; if (bus.WLAST_SDEFAULT !== (i == 2)) begin n_bad++; $display("FAIL def_wlast[%0d] got %b want %b", i, bus.WLAST_SDEFAULT, (i == 2)); end
      n_cmp++; if ({bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT, bus.WREADY_M1} !== 4'b0011)
        begin n_bad++; $display("FAIL def_beat[%0d] got %b want 0011", i, {bus.WVALID_S0, bus.WVALID_S1, bus.WVALID_SDEFAULT, bus.WREADY_M1}); end
      step();
    end
    idle_inputs();
    #1;
    n_cmp++; if (bus.w_done !== 1'b1)  begin n_bad++; $display("FAIL def_done got %b want 1", bus.w_done); end
    n_cmp++; if (bus.aw_hold !== 1'b0) begin n_bad++; $display("FAIL def_hold_drop got %b want 0", bus.aw_hold); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    drive_aw(1, 4'h3);
    step();
    clear_aw();
    bus.WVALID_M1 = 1; bus.WREADY_S1 = 1;
    step(); step();
    rst = 1;
    step(); step();
    n_cmp++; if (bus.aw_hold !== 1'b0)   begin n_bad++; $display("FAIL rstmid_hold got %b want 0", bus.aw_hold); end
    n_cmp++; if (bus.WVALID_S1 !== 1'b0) begin n_bad++; $display("FAIL rstmid_wvalid got %b want 0", bus.WVALID_S1); end
    n_cmp++; if (bus.w_done !== 1'b0)    begin n_bad++; $display("FAIL rstmid_done got %b want 0", bus.w_done); end
    n_cmp++; if (bus.wlast_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err_clear got %b want 0", bus.wlast_err); end
    rst = 0;
    idle_inputs();
    step();
    n_cmp++; if (bus.w_done !== 1'b0)    begin n_bad++; $display("FAIL rstmid_done_after got %b want 0", bus.w_done); end
    drive_aw(0, 4'h0);
    step();
    clear_aw();
    bus.WVALID_M1 = 1; bus.WREADY_S0 = 1; bus.WLAST_M1 = 1;
    #1;
    n_cmp++; if ({bus.WVALID_S0, bus.WLAST_S0, bus.WREADY_M1} !== 3'b111)
      begin n_bad++; $display("FAIL rstmid_new_beat got %b want 111", {bus.WVALID_S0, bus.WLAST_S0, bus.WREADY_M1}); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (bus.w_done !== 1'b1)    begin n_bad++; $display("FAIL rstmid_new_done got %b want 1", bus.w_done); end
    step();
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_single_beat();
    test_burst_s1();
    test_same_cycle();
    test_wlast_err();
    test_default_slave();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
